// File: rtl/disp_pkg.sv
// Shared types and constants for the display arbiter.
package disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  localparam logic [3:0] BLANK_ALL = 4'hF;
  localparam int DEF_N_SRC = 3;
  // Four full 2^16-cycle scan frames per grant.
  localparam int DEF_DWELL = 262144;
  localparam int DEF_GAP   = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: searches upward from last_owner+1, wrapping.
module rr_pick #(
  parameter int N_SRC = 3,
  parameter int OW    = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic [N_SRC-1:0] req,
  input  logic [OW-1:0]    last_owner,
  output logic [N_SRC-1:0] pick,
  output logic [OW-1:0]    pick_idx,
  output logic             valid
);

  // First set request bit after the last owner wins.
  always_comb begin
    int idx;
    idx      = 0;
    pick     = '0;
    pick_idx = '0;
    valid    = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      idx = (int'(last_owner) + 1 + i) % N_SRC;
      if (!valid && req[idx]) begin
        valid     = 1'b1;
        pick[idx] = 1'b1;
        pick_idx  = OW'(idx);
      end
    end
  end

endmodule

// File: rtl/display_arbiter.sv
// Shares one 4-digit hex display among N_SRC requesters with minimum dwell
// and a blanked gap between owners.
//
// state | meaning
// IDLE  | no owner, display dark, waiting for any request
// SHOW  | grantee's value/mask on display, dwell counter running
// GAP   | display dark between owners, gap down-counter running
module display_arbiter
  import disp_pkg::*;
#(
  parameter int N_SRC = DEF_N_SRC,
  parameter int DWELL = DEF_DWELL,
  parameter int GAP   = DEF_GAP
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC-1:0]      req,
  input  logic [16*N_SRC-1:0]   src_data,
  input  logic [4*N_SRC-1:0]    src_mask,
  output logic [N_SRC-1:0]      grant,
  output logic [15:0]           disp_value,
  output logic [3:0]            disp_blank,
  output logic                  busy
);

  localparam int OW      = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int DW      = (DWELL > 1) ? $clog2(DWELL) : 1;
  // A zero gap still costs one blanked cycle.
  localparam int GAP_EFF = (GAP < 1) ? 1 : GAP;
  localparam int GW      = (GAP_EFF > 1) ? $clog2(GAP_EFF) : 1;
  localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL - 1);
  localparam logic [GW-1:0] GAP_LOAD  = GW'(GAP_EFF - 1);

  state_e             state_q, state_d;
  logic [N_SRC-1:0]   grant_q, grant_d;
  logic [15:0]        value_q, value_d;
  logic [3:0]         blank_q, blank_d;
  logic               busy_q, busy_d;
  logic [DW-1:0]      dwell_q, dwell_d;
  logic [GW-1:0]      gap_q, gap_d;
  logic [OW-1:0]      last_q, last_d;

  logic [N_SRC-1:0]   pick_oh;
  logic [OW-1:0]      pick_idx;
  logic               pick_valid;
  logic [15:0]        owner_data;
  logic [3:0]         owner_mask;
  logic               owner_req;
  logic               other_req;

  rr_pick #(.N_SRC(N_SRC), .OW(OW)) u_pick (
    .req        (req),
    .last_owner (last_q),
    .pick       (pick_oh),
    .pick_idx   (pick_idx),
    .valid      (pick_valid)
  );

  // Select the current owner's data and mask.
  always_comb begin
    owner_data = '0;
    owner_mask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (last_q == OW'(i)) begin
        owner_data = src_data[16*i +: 16];
        owner_mask = src_mask[4*i +: 4];
      end
    end
  end

  assign owner_req = |(req & grant_q);
  assign other_req = |(req & ~grant_q);

  // Next-state and next-output computation.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    value_d = value_q;
    blank_d = blank_q;
    dwell_d = dwell_q;
    gap_d   = gap_q;
    last_d  = last_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          state_d = ST_SHOW;
          grant_d = pick_oh;
          last_d  = pick_idx;
          dwell_d = '0;
        end
      end
      ST_SHOW: begin
        // Release by the owner takes priority over a dwell-based handover.
        if (!owner_req || (dwell_q == DWELL_MAX && other_req)) begin
          state_d = ST_GAP;
          grant_d = '0;
          blank_d = BLANK_ALL;
          gap_d   = GAP_LOAD;
        end else begin
          value_d = owner_data;
          blank_d = ~owner_mask;
          if (dwell_q != DWELL_MAX) dwell_d = dwell_q + 1'b1;
        end
      end
      ST_GAP: begin
        if (gap_q != '0) begin
          gap_d = gap_q - 1'b1;
        end else if (pick_valid) begin
          state_d = ST_SHOW;
          grant_d = pick_oh;
          last_d  = pick_idx;
          dwell_d = '0;
        end else begin
          state_d = ST_IDLE;
          value_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
        value_d = '0;
        blank_d = BLANK_ALL;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      value_q <= '0;
      blank_q <= BLANK_ALL;
      busy_q  <= 1'b0;
      dwell_q <= '0;
      gap_q   <= '0;
      last_q  <= OW'(N_SRC - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      value_q <= value_d;
      blank_q <= blank_d;
      busy_q  <= busy_d;
      dwell_q <= dwell_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
    end
  end

  assign grant      = grant_q;
  assign disp_value = value_q;
  assign disp_blank = blank_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Bench for display_arbiter with N_SRC=3, DWELL=8, GAP=2.
module tb_display_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [47:0] src_data;
  logic [11:0] src_mask;
  logic [2:0]  grant;
  logic [15:0] disp_value;
  logic [3:0]  disp_blank;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic [2:0]  g;
    logic [3:0]  b;
    logic [15:0] v;
    logic        bz;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  logic [15:0] dv [3];

  display_arbiter #(.N_SRC(3), .DWELL(8), .GAP(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .src_data   (src_data),
    .src_mask   (src_mask),
    .grant      (grant),
    .disp_value (disp_value),
    .disp_blank (disp_blank),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_src(input int i, input logic [15:0] v, input logic [3:0] m);
    src_data[16*i +: 16] = v;
    src_mask[4*i +: 4]   = m;
  endtask

  // Push the expected outputs for the next clock edge, then compare at the
  // following falling edge.
  task automatic tick(input string tag, input logic [2:0] g, input logic [3:0] b,
                      input logic [15:0] v, input logic bz);
    exp_t  e;
    string t;
    e.g = g; e.b = b; e.v = v; e.bz = bz;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    check({t, "/grant"}, 32'(grant), 32'(e.g));
    check({t, "/blank"}, 32'(disp_blank), 32'(e.b));
    check({t, "/value"}, 32'(disp_value), 32'(e.v));
    check({t, "/busy"},  32'(busy), 32'(e.bz));
  endtask

  task automatic show(input string tag, input logic [2:0] g, input logic [3:0] b, input logic [15:0] v);
    tick(tag, g, b, v, 1'b1);
  endtask

  task automatic gapc(input string tag, input logic [15:0] v);
    tick(tag, 3'b000, 4'hF, v, 1'b1);
  endtask

  task automatic idle(input string tag);
    tick(tag, 3'b000, 4'hF, 16'h0000, 1'b0);
  endtask

  initial begin
    logic [15:0] cv;
    logic [2:0]  gexp;
    dv[0] = 16'hA000;
    dv[1] = 16'hB111;
    dv[2] = 16'hC222;
    rst = 1'b0;
    req = 3'b000;
    src_data = '0;
    src_mask = '1;
    repeat (3) @(negedge clk);
    check("rst/grant", 32'(grant), 32'h0);
    check("rst/blank", 32'(disp_blank), 32'hF);
    check("rst/value", 32'(disp_value), 32'h0);
    check("rst/busy",  32'(busy), 32'h0);
    rst = 1'b1;
    idle("s0_idle");

    // First grant after reset goes to source 0; value lands one cycle later.
    set_src(0, 16'h1234, 4'hF);
    req = 3'b001;
    show("s1_grant", 3'b001, 4'hF, 16'h0000);
    show("s1_data",  3'b001, 4'h0, 16'h1234);

    // Sole requester keeps the display well past dwell; live data tracks.
    for (int i = 0; i < 100; i++) begin
      if (i == 50) set_src(0, 16'h4321, 4'hF);
      cv = (i >= 50) ? 16'h4321 : 16'h1234;
      show("s2_hold", 3'b001, 4'h0, cv);
    end
    req = 3'b000;
    gapc("s2_gap1", 16'h4321);
    gapc("s2_gap2", 16'h4321);
    idle("s2_idle");

    // Round-robin skips idle source 1; async reset mid-SHOW.
    set_src(2, dv[2], 4'hF);
    req = 3'b100;
    show("s3_grant", 3'b100, 4'hF, 16'h0000);
    repeat (3) show("s3_data", 3'b100, 4'h0, dv[2]);
    rst = 1'b0;
    #1;
    check("s3_arst/grant", 32'(grant), 32'h0);
    check("s3_arst/blank", 32'(disp_blank), 32'hF);
    check("s3_arst/value", 32'(disp_value), 32'h0);
    check("s3_arst/busy",  32'(busy), 32'h0);
    @(negedge clk);
    set_src(0, dv[0], 4'hF);
    set_src(1, dv[1], 4'hF);
    req = 3'b111;
    rst = 1'b1;
    show("s4_first", 3'b001, 4'hF, 16'h0000);

    // All three requesting: 8 SHOW cycles each, 2 blanked cycles between.
    for (int k = 0; k < 3; k++) begin
      gexp = 3'(1 << k);
      if (k > 0) show("s4_enter", gexp, 4'hF, dv[k-1]);
      repeat (7) show("s4_dwell", gexp, 4'h0, dv[k]);
      repeat (2) gapc("s4_gap", dv[k]);
    end
    show("s5_enter", 3'b001, 4'hF, dv[2]);
    show("s5_c2", 3'b001, 4'h0, dv[0]);
    show("s5_c3", 3'b001, 4'h0, dv[0]);

    // Owner 0 releases early; req changes inside GAP are ignored until its end.
    req = 3'b010;
    gapc("s5_gap1", dv[0]);
    req = 3'b101;
    gapc("s5_gap2", dv[0]);
    req = 3'b010;
    set_src(1, dv[1], 4'b0011);
    show("s6_grant", 3'b010, 4'hF, dv[0]);
    show("s6_mask",  3'b010, 4'b1100, dv[1]);
    show("s6_mask2", 3'b010, 4'b1100, dv[1]);

    // Release and new request in the same cycle still takes a GAP; all drop -> IDLE.
    req = 3'b100;
    gapc("s6_gap1", dv[1]);
    req = 3'b000;
    gapc("s6_gap2", dv[1]);
    idle("s6_idle");
    idle("s6_idle2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
